// File: rtl/uart_pkg.sv
// uart_pkg: shared UART FSM state encoding, parity codes and default bit period
package uart_pkg;
  localparam int CLKS_PER_BIT_DEFAULT = 10416;
  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, BREAK} uart_state_t;
endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous FIFO with full/empty flags and a dropped-write pulse
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic             overflow
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic push, pop;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign pop = rd_en && !empty;
  assign push = wr_en && (!full || pop);
  assign rd_data = mem[rd_ptr];
  // storage array, written only on an accepted push
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= wr_data;
  // pointers wrap naturally; a write refused while full raises overflow for one cycle
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      wr_ptr   <= wr_ptr + AW'(push);
      rd_ptr   <= rd_ptr + AW'(pop);
      count    <= count + (AW+1)'(push) - (AW+1)'(pop);
      overflow <= wr_en && !push;
    end
endmodule

// File: rtl/uart_tx_param.sv
// uart_tx_param: queued UART transmitter with configurable framing; UART_TX_BREAK_EN adds a brk input
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = PARITY_NONE,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
`ifdef UART_TX_BREAK_EN
  input  logic       brk,
`endif
  output logic       tx,
  output logic       busy,
  output logic       full,
  output logic       empty,
  output logic       overflow
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0] DATA_LAST = 3'(DATA_BITS - 1);
  localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);
  localparam logic [7:0] MASK = 8'((1 << DATA_BITS) - 1);
  uart_state_t state;
  logic [CW-1:0] cnt;
  logic [2:0] idx;
  logic [7:0] sh, head;
  logic par_bit, head_par, has_data, pop, bit_end;
  uart_tx_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .rd_en(pop),
    .rd_data(head), .full(full), .empty(empty), .overflow(overflow)
  );
  assign bit_end = cnt == CNT_LAST;
  assign head_par = (PARITY == PARITY_ODD) ? ~^(head & MASK) : ^(head & MASK);
`ifdef UART_TX_BREAK_EN
  assign pop = (state == IDLE && has_data && !empty && !brk) ||
               (state == STOP && bit_end && idx == STOP_LAST && !empty);
`else
  assign pop = (state == IDLE && has_data && !empty) ||
               (state == STOP && bit_end && idx == STOP_LAST && !empty);
`endif
  assign busy = state != IDLE || !empty;
  // frame sequencer; has_data delays the idle pickup by one cycle so a fresh write leaves tx high for one extra edge
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state    <= IDLE;
      tx       <= 1'b1;
      cnt      <= '0;
      idx      <= '0;
      sh       <= '0;
      par_bit  <= 1'b0;
      has_data <= 1'b0;
    end else begin
      has_data <= !empty;
      cnt      <= bit_end ? '0 : cnt + 1'b1;
      case (state)
        IDLE: begin
          tx  <= 1'b1;
          cnt <= '0;
          idx <= '0;
`ifdef UART_TX_BREAK_EN
          if (brk) begin
            state <= BREAK;
            tx    <= 1'b0;
          end else
`endif
          if (pop) begin
            state   <= START;
            tx      <= 1'b0;
            sh      <= head;
            par_bit <= head_par;
          end
        end
        START: if (bit_end) begin
          state <= DATA;
          tx    <= sh[0];
          idx   <= '0;
        end
        DATA: if (bit_end) begin
          if (idx == DATA_LAST) begin
            state <= (PARITY != PARITY_NONE) ? PAR : STOP;
            tx    <= (PARITY != PARITY_NONE) ? par_bit : 1'b1;
            idx   <= '0;
          end else begin
            sh  <= sh >> 1;
            tx  <= sh[1];
            idx <= idx + 1'b1;
          end
        end
        PAR: if (bit_end) begin
          state <= STOP;
          tx    <= 1'b1;
        end
        STOP: if (bit_end) begin
          if (idx != STOP_LAST) idx <= idx + 1'b1;
          else if (pop) begin
            state   <= START;
            tx      <= 1'b0;
            sh      <= head;
            par_bit <= head_par;
            idx     <= '0;
          end else state <= IDLE;
        end
`ifdef UART_TX_BREAK_EN
        BREAK: if (brk) begin
          tx  <= 1'b0;
          cnt <= '0;
        end else begin
          tx <= 1'b1;
          if (bit_end) state <= IDLE;
        end
`endif
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
endmodule
